arb_sram_stream_buffer: RTL and testbench

Elastic 32-bit word buffer between the readout arbiter output and the SRAM FIFO write port, clocked on BUS_CLK. It absorbs short SRAM write stalls and applies backpressure to the arbiter. It drives a near-full level used as the trigger veto. Optionally it inserts periodic heartbeat words so that software can detect stream gaps.

---
 rtl/mio_stream_pkg.sv | 16 +
 rtl/stream_buf_mem.sv | 49 ++++
 rtl/arb_sram_stream_buffer.sv | 140 ++++++++++++++
 tb/tb_arb_sram_stream_buffer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_stream_pkg.sv
// Shared constants for the arbiter-to-SRAM stream path: word width,
// heartbeat word layout and the occupancy-counter width helper.
package mio_stream_pkg;

   localparam int WORD_W = 32;

   // Heartbeat words carry this tag in bits [31:28] above the sequence number.
   localparam logic [3:0] HB_IDENTIFIER = 4'b0111;
   localparam int HB_SEQ_W = 28;

   // Occupancy runs 0..depth inclusive, so it needs one more code than depth.
   function automatic int level_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/stream_buf_mem.sv
// Circular word store for the stream buffer. Write and read pointers wrap
// modulo DEPTH (a power of two); the head word is presented combinationally
// at the read pointer. Occupancy tracking and overflow protection belong to
// the instantiating block.
module stream_buf_mem
   import mio_stream_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = WORD_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;

   // Word storage write port.
   // NOTE: the array has no reset; stale contents are never observable
   // because the pointers are cleared and the head is masked while empty.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // Pointer advance; natural overflow of the AW-bit counters is the wrap.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values of the others.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (i_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/arb_sram_stream_buffer.sv
// Elastic word buffer between the readout arbiter and the SRAM FIFO write
// port. Absorbs short write stalls, backpressures the arbiter through
// IN_READY and reports a registered occupancy with a near-full veto flag.
// Build option: define ARB_SRAM_HEARTBEAT_EN to insert periodic heartbeat
// words {4'b0111, seq[27:0]} every HB_PERIOD cycles while HB_ENABLE=1.
module arb_sram_stream_buffer
   import mio_stream_pkg::*;
#(
   parameter int DEPTH           = 16,
   parameter int NEAR_FULL_LEVEL = 12,
   parameter int HB_PERIOD       = 4096
) (
   input  logic                      BUS_CLK,
   input  logic                      BUS_RST,
   input  logic                      IN_VALID,
   input  logic [WORD_W-1:0]         IN_DATA,
   output logic                      IN_READY,
   input  logic                      OUT_READ_NEXT,
   output logic                      OUT_EMPTY,
   output logic [WORD_W-1:0]         OUT_DATA,
   output logic [level_w(DEPTH)-1:0] LEVEL,
   output logic                      NEAR_FULL,
   output logic                      READ_ERROR,
   input  logic                      HB_ENABLE
);

   localparam int            LW      = level_w(DEPTH);
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] NF_L    = LW'(NEAR_FULL_LEVEL);

   logic [LW-1:0]     r_level;
   logic [LW-1:0]     w_level_nxt;
   logic              r_near_full;
   logic              r_read_error;
   logic              r_run;
   logic              w_empty;
   logic              w_not_full;
   logic              w_push;
   logic              w_pop;
   logic              w_wr_en;
   logic              w_hb_insert;
   logic [WORD_W-1:0] w_hb_word;
   logic [WORD_W-1:0] w_wr_data;
   logic [WORD_W-1:0] w_rd_data;

   // Handshakes derive only from registered state, never from IN_VALID.
   // r_run holds IN_READY low until the first edge out of reset.
   assign w_empty    = (r_level == '0);
   assign w_not_full = (r_level < DEPTH_L);
   assign IN_READY   = r_run && w_not_full && !w_hb_insert;
   assign w_push     = IN_VALID && IN_READY;
   assign w_pop      = OUT_READ_NEXT && !w_empty;
   assign w_wr_en    = w_push || w_hb_insert;
   assign w_wr_data  = w_hb_insert ? w_hb_word : IN_DATA;

`ifdef ARB_SRAM_HEARTBEAT_EN
   logic [31:0]         r_hb_cnt;
   logic                r_hb_pending;
   logic [HB_SEQ_W-1:0] r_hb_seq;
   logic [HB_SEQ_W-1:0] r_hb_word_seq;
   logic                w_hb_expire;

   assign w_hb_expire = HB_ENABLE && (r_hb_cnt == 32'(HB_PERIOD - 1));
   assign w_hb_insert = r_hb_pending && w_not_full;
   assign w_hb_word   = {HB_IDENTIFIER, r_hb_word_seq};

   // Period counter, sequence numbering and pending-insert flag. A pending
   // heartbeat waits while full; a further expiry merges into it but still
   // advances the sequence number.
   always_ff @(posedge BUS_CLK) begin
      if (!BUS_RST) begin
         r_hb_cnt      <= '0;
         r_hb_pending  <= 1'b0;
         r_hb_seq      <= '0;
         r_hb_word_seq <= '0;
      end else begin
         if (!HB_ENABLE || w_hb_expire) r_hb_cnt <= '0;
         else                           r_hb_cnt <= r_hb_cnt + 32'd1;

         if (w_hb_expire) r_hb_seq <= r_hb_seq + HB_SEQ_W'(1);
         if (w_hb_expire && (!r_hb_pending || w_hb_insert)) r_hb_word_seq <= r_hb_seq;

         if (!HB_ENABLE)       r_hb_pending <= 1'b0;
         else if (w_hb_expire) r_hb_pending <= 1'b1;
         else if (w_hb_insert) r_hb_pending <= 1'b0;
      end
   end
`else
   logic w_unused_hb;

   assign w_hb_insert = 1'b0;
   assign w_hb_word   = '0;
   assign w_unused_hb = HB_ENABLE & (HB_PERIOD > 0);
`endif

   // Next occupancy: a simultaneous write and pop leaves it unchanged.
   // NOTE: every output gets a default first so no path infers a latch.
   always_comb begin
      w_level_nxt = r_level;
      case ({w_wr_en, w_pop})
         2'b10:   w_level_nxt = r_level + LW'(1);
         2'b01:   w_level_nxt = r_level - LW'(1);
         default: w_level_nxt = r_level;
      endcase
   end

   // Occupancy, near-full flag and sticky underflow error.
   always_ff @(posedge BUS_CLK) begin
      if (!BUS_RST) begin
         r_run        <= 1'b0;
         r_level      <= '0;
         r_near_full  <= 1'b0;
         r_read_error <= 1'b0;
      end else begin
         r_run       <= 1'b1;
         r_level     <= w_level_nxt;
         r_near_full <= (w_level_nxt >= NF_L);
         if (OUT_READ_NEXT && w_empty) r_read_error <= 1'b1;
      end
   end

   stream_buf_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WORD_W)
   ) u_mem (
      .i_clk     (BUS_CLK),
      .i_rst_n   (BUS_RST),
      .i_wr_en   (w_wr_en),
      .i_wr_data (w_wr_data),
      .i_rd_en   (w_pop),
      .o_rd_data (w_rd_data)
   );

   assign OUT_EMPTY  = w_empty;
   assign OUT_DATA   = w_empty ? '0 : w_rd_data;
   assign LEVEL      = r_level;
   assign NEAR_FULL  = r_near_full;
   assign READ_ERROR = r_read_error;

endmodule

// File: tb/tb_arb_sram_stream_buffer.sv
// Testbench for arb_sram_stream_buffer (DEPTH=8, NEAR_FULL_LEVEL=6).
// Accepted words go into a scoreboard queue; a negedge monitor pops and
// compares on every DUT pop. Directed checks cover levels and flags.
module tb_arb_sram_stream_buffer;
   import mio_stream_pkg::*;

   localparam int DEPTH = 8;
   localparam int NFL   = 6;
   localparam int HBP   = 16;
   localparam int LW    = level_w(DEPTH);

   logic          BUS_CLK       = 1'b0;
   logic          BUS_RST       = 1'b0;
   logic          IN_VALID      = 1'b0;
   logic [31:0]   IN_DATA       = '0;
   logic          OUT_READ_NEXT = 1'b0;
   logic          HB_ENABLE     = 1'b0;
   logic          IN_READY;
   logic          OUT_EMPTY;
   logic [31:0]   OUT_DATA;
   logic [LW-1:0] LEVEL;
   logic          NEAR_FULL;
   logic          READ_ERROR;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] sb_q[$];
   int          cyc_cnt  = 0;

   always #5 BUS_CLK = ~BUS_CLK;

   arb_sram_stream_buffer #(
      .DEPTH           (DEPTH),
      .NEAR_FULL_LEVEL (NFL),
      .HB_PERIOD       (HBP)
   ) dut (
      .BUS_CLK       (BUS_CLK),
      .BUS_RST       (BUS_RST),
      .IN_VALID      (IN_VALID),
      .IN_DATA       (IN_DATA),
      .IN_READY      (IN_READY),
      .OUT_READ_NEXT (OUT_READ_NEXT),
      .OUT_EMPTY     (OUT_EMPTY),
      .OUT_DATA      (OUT_DATA),
      .LEVEL         (LEVEL),
      .NEAR_FULL     (NEAR_FULL),
      .READ_ERROR    (READ_ERROR),
      .HB_ENABLE     (HB_ENABLE)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Advance to just after the next active edge.
   task automatic cyc();
      @(posedge BUS_CLK);
      #1;
   endtask

   task automatic check_lvl(input string name, input int lvl, input bit nf);
      check({name, "_level"}, 32'(LEVEL), 32'(lvl));
      check({name, "_near_full"}, 32'(NEAR_FULL), 32'(nf));
   endtask

`ifdef ARB_SRAM_HEARTBEAT_EN
   bit                  hb_mode     = 1'b0;
   logic [HB_SEQ_W-1:0] hb_exp_seq  = '0;
   int                  hb_last_cyc = -1;
   int                  rdy_low_run = 0;
`endif

   // Monitor: compare popped words against the scoreboard, record accepts.
   always @(negedge BUS_CLK) begin
      cyc_cnt++;
      if (!BUS_RST) begin
         sb_q.delete();
      end else begin
         if (OUT_EMPTY) check("empty_masks_data", OUT_DATA, 32'h0);
         if (OUT_READ_NEXT && !OUT_EMPTY) begin
`ifdef ARB_SRAM_HEARTBEAT_EN
            if (hb_mode && OUT_DATA[31:28] == HB_IDENTIFIER) begin
               check("hb_word", OUT_DATA, {HB_IDENTIFIER, hb_exp_seq});
               if (hb_last_cyc >= 0) check("hb_spacing", 32'(cyc_cnt - hb_last_cyc), 32'(HBP));
               hb_last_cyc = cyc_cnt;
               hb_exp_seq  = hb_exp_seq + 1'b1;
            end else
`endif
            if (sb_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL pop_unexpected: got 0x%08h expected no word", OUT_DATA);
            end else begin
               check("pop_data", OUT_DATA, sb_q.pop_front());
            end
         end
         if (IN_VALID && IN_READY) sb_q.push_back(IN_DATA);
`ifdef ARB_SRAM_HEARTBEAT_EN
         if (hb_mode) begin
            if (!IN_READY) begin
               rdy_low_run++;
            end else begin
               if (rdy_low_run != 0) check("hb_ready_gap", 32'(rdy_low_run), 32'd1);
               rdy_low_run = 0;
            end
         end
`endif
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset then idle.
      repeat (3) cyc();
      check("rst_empty", 32'(OUT_EMPTY), 32'd1);
      check("rst_data", OUT_DATA, 32'h0);
      check("rst_ready", 32'(IN_READY), 32'd0);
      check("rst_read_error", 32'(READ_ERROR), 32'd0);
      check_lvl("rst", 0, 1'b0);
      BUS_RST = 1'b1;
      cyc();
      check("idle_ready", 32'(IN_READY), 32'd1);
      check("idle_empty", 32'(OUT_EMPTY), 32'd1);
      check_lvl("idle", 0, 1'b0);

      // Three back-to-back pushes, then three pops.
      IN_VALID = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         IN_DATA = 32'h1000_0000 + 32'(i);
         cyc();
         if (i == 1) begin
            check("latency_empty", 32'(OUT_EMPTY), 32'd0);
            check("latency_data", OUT_DATA, 32'h1000_0001);
         end
      end
      IN_VALID = 1'b0;
      check_lvl("push3", 3, 1'b0);
      check("push3_head", OUT_DATA, 32'h1000_0001);
      OUT_READ_NEXT = 1'b1;
      repeat (3) cyc();
      OUT_READ_NEXT = 1'b0;
      check("pop3_empty", 32'(OUT_EMPTY), 32'd1);
      check("pop3_data", OUT_DATA, 32'h0);
      check_lvl("pop3", 0, 1'b0);

      // Fill to DEPTH, refused push at full, hold at full.
      IN_VALID = 1'b1;
      for (int i = 0; i < 8; i++) begin
         IN_DATA = 32'h2000_0000 + 32'(i);
         cyc();
         check_lvl("fill", i + 1, (i + 1) >= 6);
      end
      check("full_ready", 32'(IN_READY), 32'd0);
      IN_DATA       = 32'h2000_0008;
      OUT_READ_NEXT = 1'b1;
      cyc();
      OUT_READ_NEXT = 1'b0;
      check_lvl("full_pushpop", 7, 1'b1);
      check("full_pushpop_ready", 32'(IN_READY), 32'd1);
      cyc();
      check_lvl("full_retry", 8, 1'b1);
      IN_DATA = 32'h2000_0009;
      repeat (2) cyc();
      check_lvl("full_hold", 8, 1'b1);
      check("full_hold_ready", 32'(IN_READY), 32'd0);
      IN_VALID      = 1'b0;
      OUT_READ_NEXT = 1'b1;
      for (int i = 7; i >= 4; i--) begin
         cyc();
         check_lvl("drain", i, i >= 6);
      end
      OUT_READ_NEXT = 1'b0;

      // Continuous push+pop across pointer wrap at LEVEL=4.
      IN_VALID      = 1'b1;
      OUT_READ_NEXT = 1'b1;
      for (int i = 0; i < 20; i++) begin
         IN_DATA = 32'h3000_0000 + 32'(i);
         cyc();
         check("stream_level", 32'(LEVEL), 32'd4);
      end
      IN_VALID = 1'b0;
      repeat (4) cyc();
      check("stream_drained_empty", 32'(OUT_EMPTY), 32'd1);
      check("stream_sb_drained", 32'(sb_q.size()), 32'd0);
      check("no_error_yet", 32'(READ_ERROR), 32'd0);

      // Pop while empty sets the sticky error.
      cyc();
      OUT_READ_NEXT = 1'b0;
      check("underflow_error", 32'(READ_ERROR), 32'd1);
      check("underflow_level", 32'(LEVEL), 32'd0);
      IN_VALID = 1'b1;
      IN_DATA  = 32'h4000_0001;
      cyc();
      IN_VALID      = 1'b0;
      OUT_READ_NEXT = 1'b1;
      cyc();
      OUT_READ_NEXT = 1'b0;
      check("error_sticky", 32'(READ_ERROR), 32'd1);
      check("error_sticky_empty", 32'(OUT_EMPTY), 32'd1);

      // Reset mid-transfer discards buffered words and the offered one.
      IN_VALID = 1'b1;
      IN_DATA  = 32'h5000_0001;
      cyc();
      IN_DATA = 32'h5000_0002;
      cyc();
      IN_DATA = 32'h5000_0003;
      BUS_RST = 1'b0;
      cyc();
      IN_VALID = 1'b0;
      check_lvl("midrst", 0, 1'b0);
      check("midrst_empty", 32'(OUT_EMPTY), 32'd1);
      check("midrst_data", OUT_DATA, 32'h0);
      check("midrst_ready", 32'(IN_READY), 32'd0);
      check("midrst_error_cleared", 32'(READ_ERROR), 32'd0);
      BUS_RST = 1'b1;
      cyc();
      check("post_rst_ready", 32'(IN_READY), 32'd1);
      check("post_rst_level", 32'(LEVEL), 32'd0);

`ifdef ARB_SRAM_HEARTBEAT_EN
      // Heartbeat insertion with the arbiter streaming continuously.
      begin
         bit acc;
         hb_mode   = 1'b1;
         HB_ENABLE = 1'b1;
         IN_VALID  = 1'b1;
         IN_DATA   = 32'h5100_0000;
         cyc();
         OUT_READ_NEXT = 1'b1;
         for (int i = 0; i < 45; i++) begin
            @(negedge BUS_CLK);
            acc = IN_READY;
            @(posedge BUS_CLK);
            #1;
            if (acc) IN_DATA = IN_DATA + 32'd1;
         end
         IN_VALID  = 1'b0;
         HB_ENABLE = 1'b0;
         repeat (6) cyc();
         OUT_READ_NEXT = 1'b0;
         check("hb_count", 32'(hb_exp_seq), 32'd2);
         check("hb_sb_drained", 32'(sb_q.size()), 32'd0);
         hb_mode = 1'b0;
      end
`endif

      cyc();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
